hes_ctr_stream_engine: RTL and testbench
========================================

HES_CTR_STREAM_ENGINE -- requirements
Module: hes_ctr_stream_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning bytes processed per beat (1..16).
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the message-length field in beats.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port key, input, 8 bits: counter seed, sampled on an accepted start.
REQ-006 SHALL have port start, input, 1 bit: begin a new message; accepted only in IDLE.
REQ-007 SHALL have port msg_beats, input, LEN_W bits: message length in beats, sampled with start.
REQ-008 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the input beat is accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port in_data, input, 8*LANES bits: plaintext or ciphertext; lane j occupies bits [8j+7:8j].
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-013 SHALL have port out_data, output, 8*LANES bits: the result beat.
REQ-014 SHALL have port out_last, output, 1 bit: marks the final beat of the message.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle pulse when the last beat leaves the block.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and DRAIN.
- IDLE -> RUN on start when msg_beats != 0.
- RUN -> DRAIN when the final beat is accepted on input.
- DRAIN -> IDLE when the final beat handshakes on output.
REQ-018 SHALL ignore start in IDLE when msg_beats == 0 and remain in IDLE, with no done pulse.
REQ-019 SHALL ignore start outside IDLE, with no effect on the current message.
REQ-020 SHALL keep an 8-bit base counter.
- Loaded with key on an accepted start.
- Advanced by LANES, modulo 256, on each accepted input beat.
REQ-021 SHALL compute the keystream byte for lane j as SBOX((base + j) mod 256), where SBOX is the standard AES forward S-box.
REQ-022 SHALL make each out_data lane equal to in_data lane XOR keystream lane; encryption and decryption are the same operation.
REQ-023 SHALL register the output: the result appears on out_data one cycle after the input handshake (latency 1).
REQ-024 SHALL drive in_ready = (state == RUN) && (!out_valid || out_ready), so input and output can both transfer in the same cycle.
REQ-025 SHALL hold out_valid, out_data and out_last stable while out_valid && !out_ready.
REQ-026 SHALL keep a remaining-beat counter of LEN_W bits.
- Loaded with msg_beats on start.
- Decremented on each input handshake.
- The beat accepted when the counter equals 1 is the final beat; its output carries out_last = 1.
REQ-027 SHALL let the 8-bit counter wrap freely, modulo 256, across beats and within a beat.
REQ-028 SHALL allow a start in the same cycle that DRAIN exits to IDLE to take effect only on the next cycle; no beat is ever lost.
REQ-029 SHALL pulse done for exactly the cycle after the final output handshake.

Reset
REQ-030 SHALL, while rst is high, force the following regardless of clk:
- state = IDLE;
- base = 0x00;
- remaining-beat counter = 0;
- out_valid = 0, out_data = 0, out_last = 0;
- done = 0, busy = 0, in_ready = 0.
REQ-031 SHALL, when rst is asserted mid-message, abandon the message and drop any pending output beat; after release, the block SHALL wait for a new start.

Verification
REQ-032 SHALL pass this scenario: LANES=4, key=0x00, msg_beats=1, in_data=0x00000000 -> out_data=0x7B777C63, out_last=1, done pulses one cycle after the output handshake.
REQ-033 SHALL pass this wrap scenario: key=0xFE, one zero beat -> out_data=0x7C6316BB (lane counters FE, FF, 00, 01).
REQ-034 SHALL pass this round-trip scenario: encrypt 3 random beats with key=0x5A, restart with key=0x5A and feed the ciphertext back -> the original plaintext is returned, with out_last only on beat 3.
REQ-035 SHALL pass this backpressure scenario: out_ready held low for 5 cycles mid-message -> in_ready is low, out_data is held stable, no beat is duplicated or dropped, and the beat count is still exact.
REQ-036 SHALL pass this mid-message reset scenario: rst pulsed after beat 2 of 4 -> all outputs are 0 and busy=0 immediately; a new start with key=0x00 reproduces the REQ-032 result.
REQ-037 SHALL pass this ignored-start scenario: start with msg_beats=0, and start pulsed during RUN -> no state change, no done pulse, and the current message output is unaffected.

Source files
------------

// File: rtl/hes_ctr_stream_engine.sv
// Counter-mode stream cipher: each lane XORs its byte with AES S-box(base + lane).
// Encrypt and decrypt are the same operation; the result is registered with one beat of latency.
module hes_ctr_stream_engine #(
  parameter int LANES = 4,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           key,
  input  logic                 start,
  input  logic [LEN_W-1:0]     msg_beats,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [7:0]       LANES_B = 8'(LANES);
  localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] REM_ZERO = {LEN_W{1'b0}};

  // Entry 0 sits in the most significant byte, so entry x is found at byte index ~x.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  logic [1:0]         state_q, state_d;
  logic [7:0]         base_q, base_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               out_valid_q, out_valid_d;
  logic [8*LANES-1:0] out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;
  logic [8*LANES-1:0] ks_s;
  logic               in_fire_s;
  logic               out_fire_s;

  assign in_ready   = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid_q && out_ready;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign done       = done_q;

  // Keystream for the current beat; the lane counter wraps modulo 256.
  always_comb begin
    ks_s = '0;
    for (int j = 0; j < LANES; j++) begin
      ks_s[8*j +: 8] = sbox_f(base_q + 8'(j));
    end
  end

  // Next-state logic for the FSM, counters and the output register.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = out_fire_s && out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start && (msg_beats != REM_ZERO)) begin
          state_d = S_RUN;
          base_d  = key;
          rem_d   = msg_beats;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (in_fire_s) begin
          base_d = base_q + LANES_B;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (out_fire_s && out_last_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new input beat replaces the slot in the same cycle the old one drains.
    if (in_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks_s;
      out_last_d  = (rem_q == REM_ONE);
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset that also drops any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= 8'h00;
      rem_q       <= REM_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_hes_ctr_stream_engine.sv
// Directed bench for hes_ctr_stream_engine with hand-computed S-box keystream values.
module tb_hes_ctr_stream_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key;
  logic        start;
  logic [15:0] msg_beats;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  hes_ctr_stream_engine #(.LANES(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .key(key), .start(start), .msg_beats(msg_beats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_last_cyc = -1;
  logic [31:0] txq[$];
  logic [31:0] oq[$];
  logic        lq[$];
  logic [31:0] pt[$];
  logic [31:0] ct[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: values seen at the negedge are the ones the next rising edge handshakes.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      oq.push_back(out_data);
      lq.push_back(out_last);
      if (out_last) hs_last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] k, input logic [15:0] n);
    key = k;
    msg_beats = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_all(input string tag, input int budget);
    int t;
    logic fire;
    logic [31:0] dummy;
    t = 0;
    while (txq.size() > 0 && t < budget) begin
      in_valid = 1'b1;
      in_data = txq[0];
      @(negedge clk);
      fire = in_ready;
      tick();
      if (fire) dummy = txq.pop_front();
      t++;
    end
    in_valid = 1'b0;
    check({tag, "_in_timeout"}, txq.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int t;
    d0 = done_cnt;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic run_msg(input string tag, input logic [7:0] k, input logic [15:0] n);
    oq.delete();
    lq.delete();
    do_start(k, n);
    drive_all(tag, 200);
    wait_done(tag, 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int ones;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    key = 8'h00; msg_beats = 16'd0; in_data = 32'h0;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();

    // Single zero beat, key 0x00
    txq = '{32'h0};
    oq.delete(); lq.delete();
    do_start(8'h00, 16'd1);
    check("basic_busy", busy, 1'b1);
    drive_all("basic", 50);
    wait_done("basic", 50);
    check("basic_count", oq.size(), 1);
    check("basic_data", oq[0], 32'h7B777C63);
    check("basic_last", lq[0], 1'b1);
    check("basic_done_timing", done_cyc, hs_last_cyc + 1);
    check("basic_done_width", done, 1'b0);
    check("basic_idle", busy, 1'b0);

    // Counter wrap inside a beat
    txq = '{32'h0};
    run_msg("wrap", 8'hFE, 16'd1);
    check("wrap_data", oq[0], 32'h7C6316BB);
    check("wrap_last", lq[0], 1'b1);

    // Round trip with key 0x5A
    pt = '{32'h11223344, 32'h00000000, 32'hDEADBEEF};
    txq = pt;
    run_msg("rt_enc", 8'h5A, 16'd3);
    check("rt_enc_count", oq.size(), 3);
    check("rt_enc_beat0", oq[0], 32'h5D680AFA);
    check("rt_enc_beat1", oq[1], 32'hEFD0CF58);
    check("rt_enc_last0", lq[0], 1'b0);
    check("rt_enc_last1", lq[1], 1'b0);
    check("rt_enc_last2", lq[2], 1'b1);
    ct = oq;
    txq = ct;
    run_msg("rt_dec", 8'h5A, 16'd3);
    check("rt_dec_count", oq.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("rt_dec_beat%0d", i), oq[i], pt[i]);
    check("rt_dec_last2", lq[2], 1'b1);

    // Backpressure mid-message
    pt = '{32'hA5A5A5A5, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000000, 32'h13579BDF};
    txq = pt;
    oq.delete(); lq.delete();
    do_start(8'h10, 16'd6);
    fork
      drive_all("bp", 300);
      begin
        int t;
        logic [31:0] held;
        t = 0;
        while (oq.size() < 2 && t < 100) begin
          tick();
          t++;
        end
        check("bp_reach", (oq.size() >= 2), 1'b1);
        out_ready = 1'b0;
        held = 32'h0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i == 0) begin
            held = out_data;
            check("bp_valid", out_valid, 1'b1);
          end else begin
            check($sformatf("bp_stable%0d", i), out_data, held);
          end
          check($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_done("bp", 50);
    check("bp_count", oq.size(), 6);
    ones = 0;
    foreach (lq[i]) if (lq[i]) ones++;
    check("bp_last_count", ones, 1);
    check("bp_last_pos", lq[5], 1'b1);
    ct = oq;
    txq = ct;
    run_msg("bp_dec", 8'h10, 16'd6);
    check("bp_dec_count", oq.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_dec_beat%0d", i), oq[i], pt[i]);

    // Reset asserted after beat 2 of 4
    d0 = done_cnt;
    txq = '{32'h0, 32'h0};
    oq.delete(); lq.delete();
    do_start(8'h00, 16'd4);
    drive_all("mrst", 50);
    check("mrst_pending", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_data", out_data, 32'h0);
    check("mrst_out_last", out_last, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) tick();
    check("mrst_wait_busy", busy, 1'b0);
    check("mrst_wait_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    check("mrst_no_done", done_cnt, d0);
    txq = '{32'h0};
    run_msg("mrst_again", 8'h00, 16'd1);
    check("mrst_again_count", oq.size(), 1);
    check("mrst_again_data", oq[0], 32'h7B777C63);
    check("mrst_again_last", lq[0], 1'b1);

    // Ignored starts
    d0 = done_cnt;
    do_start(8'h33, 16'd0);
    tick();
    check("zlen_busy", busy, 1'b0);
    check("zlen_no_done", done_cnt, d0);
    oq.delete(); lq.delete();
    do_start(8'h00, 16'd2);
    txq = '{32'h0};
    drive_all("ign1", 50);
    do_start(8'hFF, 16'd5);
    check("ign_busy", busy, 1'b1);
    txq = '{32'h0};
    drive_all("ign2", 50);
    wait_done("ign", 50);
    check("ign_count", oq.size(), 2);
    check("ign_beat0", oq[0], 32'h7B777C63);
    check("ign_beat1", oq[1], 32'hC56F6BF2);
    check("ign_last0", lq[0], 1'b0);
    check("ign_last1", lq[1], 1'b1);
    check("ign_done_total", done_cnt, d0 + 1);
    repeat (3) tick();
    check("ign_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
